// File: rtl/cp0_exc_pkg.sv
// cp0_exc_pkg: shared constants and types for the CP0 register file and
// exception controller (register addresses, ExcCodes, excepttype encodings,
// Status/Cause bit positions).
package cp0_exc_pkg;

   // CP0 register addresses
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   // ExcCode values written into Cause[6:2]
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;

   // excepttype encodings; interrupts use 1 so the output is nonzero even
   // though their ExcCode is 0, other exceptions use their ExcCode
   localparam logic [31:0] ET_NONE = 32'h0000_0000;
   localparam logic [31:0] ET_INT  = 32'h0000_0001;
   localparam logic [31:0] ET_ERET = 32'h0000_000E;

   // Status / Cause bit positions
   localparam int STATUS_IE    = 0;
   localparam int STATUS_EXL   = 1;
   localparam int STATUS_IM_LO = 8;
   localparam int STATUS_BEV   = 22;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_IP_LO  = 8;
   localparam int CAUSE_TI     = 30;
   localparam int CAUSE_BD     = 31;

   // Synchronous exception flags, highest priority first
   typedef struct packed {
      logic adel_if;
      logic ri;
      logic ov;
      logic sys;
      logic bp;
      logic adel_mem;
      logic ades;
   } exc_flags_t;

   // Result of the priority pick
   typedef struct packed {
      logic       take;
      logic [4:0] code;
      logic       is_eret;
   } exc_sel_t;

   function automatic logic [31:0] excepttype_of(input exc_sel_t s);
      logic [31:0] r;
      if (!s.take)
         r = ET_NONE;
      else if (s.is_eret)
         r = ET_ERET;
      else if (s.code == EXC_INT)
         r = ET_INT;
      else
         r = {27'd0, s.code};
      return r;
   endfunction

endpackage

// File: rtl/cp0_exc_prio.sv
// exc_prio: pure combinational priority encoder selecting the single
// exception (or eret) taken this cycle.
module exc_prio
   import cp0_exc_pkg::*;
(
   input  exc_flags_t i_flags,
   input  logic       i_int_pending,
   input  logic       i_eret,
   output exc_sel_t   o_sel
);

   // Fixed priority: Int, AdEL-fetch, RI, Ov, Sys, Bp, AdEL-data, AdES, eret
   always_comb begin
      o_sel      = '0;
      o_sel.take = 1'b1;
      if (i_int_pending)          o_sel.code = EXC_INT;
      else if (i_flags.adel_if)   o_sel.code = EXC_ADEL;
      else if (i_flags.ri)        o_sel.code = EXC_RI;
      else if (i_flags.ov)        o_sel.code = EXC_OV;
      else if (i_flags.sys)       o_sel.code = EXC_SYS;
      else if (i_flags.bp)        o_sel.code = EXC_BP;
      else if (i_flags.adel_mem)  o_sel.code = EXC_ADEL;
      else if (i_flags.ades)      o_sel.code = EXC_ADES;
      else if (i_eret)            o_sel.is_eret = 1'b1;
      else                        o_sel.take = 1'b0;
   end

endmodule

// File: rtl/cp0_exc.sv
// cp0_exc: CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC)
// and M-stage exception controller. Optional macro CP0_TIMER_INT_EN routes
// the Count==Compare timer (Cause.TI) onto interrupt line 7.
module cp0_exc
   import cp0_exc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stallM,
   input  logic [31:0] pcM,
   input  logic        in_dsM,
   input  logic        syscallM,
   input  logic        breakM,
   input  logic        eretM,
   input  logic        riM,
   input  logic        ovM,
   input  logic        adel_ifM,
   input  logic        adel_memM,
   input  logic        adesM,
   input  logic [31:0] bad_addrM,
   input  logic [5:0]  hw_int,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   output logic [31:0] excepttype,
   output logic        flush,
   output logic [31:0] newpc,
   output logic [31:0] epc_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o
);

   logic [31:0] r_badvaddr, r_count, r_compare, r_epc;
   logic        r_tick, r_exl, r_ie, r_bd;
   logic [7:0]  r_im;
   logic [4:0]  r_excode;
   logic [1:0]  r_ip_sw;
   logic [5:0]  r_ip_hw;

   logic        w_ti, w_active, w_take, w_wr, w_addr_err, w_int_pending;
   logic [7:0]  w_ip;
   logic [31:0] w_status, w_cause;
   exc_flags_t  w_flags;
   exc_sel_t    w_sel;

`ifdef CP0_TIMER_INT_EN
   logic r_ti;

   // Timer flag: set the cycle after Count matches Compare, cleared by a Compare write
   always_ff @(posedge clk) begin
      if (rst)
         r_ti <= 1'b0;
      else if (w_wr && waddr == CP0_COMPARE)
         r_ti <= 1'b0;
      else if (r_count == r_compare)
         r_ti <= 1'b1;
   end

   assign w_ti = r_ti;
`else
   assign w_ti = 1'b0;
`endif

   assign w_ip          = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
   assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));
   assign w_status      = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
   assign w_cause       = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_excode, 2'b00};

   assign w_flags = '{adel_if: adel_ifM, ri: riM, ov: ovM, sys: syscallM,
                      bp: breakM, adel_mem: adel_memM, ades: adesM};

   exc_prio u_prio (
      .i_flags       (w_flags),
      .i_int_pending (w_int_pending),
      .i_eret        (eretM),
      .o_sel         (w_sel)
   );

   // A stall or reset suppresses every commit and redirect this cycle
   assign w_active   = ~rst & ~stallM;
   assign w_take     = w_sel.take & w_active;
   assign w_wr       = we & w_active & ~w_sel.take;
   assign w_addr_err = ~w_sel.is_eret & (w_sel.code == EXC_ADEL || w_sel.code == EXC_ADES);

   assign excepttype = w_take ? excepttype_of(w_sel) : ET_NONE;
   assign flush      = w_take;
   assign newpc      = !w_take ? 32'd0 : (w_sel.is_eret ? r_epc : EXC_VECTOR);

   assign epc_o    = r_epc;
   assign status_o = w_status;
   assign cause_o  = w_cause;

   // mfc0 read port: pre-write register values, no bypass
   always_comb begin
      rdata = 32'd0;
      case (raddr)
         CP0_BADVADDR: rdata = r_badvaddr;
         CP0_COUNT:    rdata = r_count;
         CP0_COMPARE:  rdata = r_compare;
         CP0_STATUS:   rdata = w_status;
         CP0_CAUSE:    rdata = w_cause;
         CP0_EPC:      rdata = r_epc;
         default:      rdata = 32'd0;
      endcase
   end

   // Register commit: Count/hw IP every cycle, then exception/eret or mtc0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_badvaddr <= 32'd0;
         r_count    <= 32'd0;
         r_compare  <= 32'd0;
         r_epc      <= 32'd0;
         r_tick     <= 1'b0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_im       <= 8'd0;
         r_excode   <= 5'd0;
         r_ip_sw    <= 2'd0;
         r_ip_hw    <= 6'd0;
      end else begin
         r_ip_hw <= hw_int;

         // Count advances on every second cycle; an mtc0 restarts the phase
         if (w_wr && waddr == CP0_COUNT) begin
            r_count <= wdata;
            r_tick  <= 1'b0;
         end else begin
            r_tick <= ~r_tick;
            if (r_tick)
               r_count <= r_count + 32'd1;
         end

         if (w_take) begin
            if (w_sel.is_eret) begin
               r_exl <= 1'b0;
            end else begin
               // Nested exceptions keep the original return point
               if (!r_exl) begin
                  r_epc <= in_dsM ? pcM - 32'd4 : pcM;
                  r_bd  <= in_dsM;
               end
               r_exl    <= 1'b1;
               r_excode <= w_sel.code;
               if (w_addr_err)
                  r_badvaddr <= adel_ifM ? pcM : bad_addrM;
            end
         end else if (w_wr) begin
            case (waddr)
               CP0_COMPARE: r_compare <= wdata;
               CP0_STATUS: begin
                  r_im  <= wdata[15:8];
                  r_exl <= wdata[STATUS_EXL];
                  r_ie  <= wdata[STATUS_IE];
               end
               CP0_CAUSE:   r_ip_sw <= wdata[9:8];
               CP0_EPC:     r_epc   <= wdata;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed + randomized bench for cp0_exc with an architectural
// reference model checked every cycle. Honours CP0_TIMER_INT_EN.
module tb_cp0_exc;

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        rst, stallM, in_dsM, syscallM, breakM, eretM, riM, ovM;
   logic        adel_ifM, adel_memM, adesM, we, flush;
   logic [31:0] pcM, bad_addrM, wdata, rdata, excepttype, newpc;
   logic [31:0] epc_o, status_o, cause_o;
   logic [5:0]  hw_int;
   logic [4:0]  waddr, raddr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cp0_exc #(.EXC_VECTOR(VEC)) dut (
      .clk(clk), .rst(rst), .stallM(stallM), .pcM(pcM), .in_dsM(in_dsM),
      .syscallM(syscallM), .breakM(breakM), .eretM(eretM), .riM(riM),
      .ovM(ovM), .adel_ifM(adel_ifM), .adel_memM(adel_memM), .adesM(adesM),
      .bad_addrM(bad_addrM), .hw_int(hw_int), .we(we), .waddr(waddr),
      .wdata(wdata), .raddr(raddr), .rdata(rdata), .excepttype(excepttype),
      .flush(flush), .newpc(newpc), .epc_o(epc_o), .status_o(status_o),
      .cause_o(cause_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- architectural reference model ----------------
   bit          m_valid = 1'b0;
   logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
   bit          m_half, m_ti;
   logic [5:0]  m_hw;

   function automatic logic [31:0] m_cause_read();
      logic [31:0] c;
      c = m_cause;
      c[15:10] = m_hw;
      if (m_ti) begin
         c[30] = 1'b1;
         c[15] = 1'b1;
      end
      return c;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause_read();
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   // Which event (if any) is taken this cycle, from the priority list
   function automatic void model_comb(output bit take, output bit er,
                                      output logic [4:0] code, output int idx);
      bit fl [8];
      int codes [8];
      logic [31:0] cr;
      bit pend;
      cr    = m_cause_read();
      pend  = m_status[0] && !m_status[1] && ((cr[15:8] & m_status[15:8]) != 8'd0);
      fl    = '{pend, adel_ifM, riM, ovM, syscallM, breakM, adel_memM, adesM};
      codes = '{0, 4, 10, 12, 8, 9, 4, 5};
      take = 1'b0; er = 1'b0; code = 5'd0; idx = -1;
      if (rst || stallM) return;
      for (int i = 0; i < 8; i++) begin
         if (fl[i]) begin
            take = 1'b1; code = 5'(codes[i]); idx = i;
            return;
         end
      end
      if (eretM) begin
         take = 1'b1; er = 1'b1;
      end
   endfunction

   // Model state update at each rising edge
   always @(posedge clk) begin
      bit take, er, wr;
      logic [4:0] code;
      int idx;
      logic [31:0] oc, ocmp;
      if (rst) begin
         m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0;
         m_count = 0; m_compare = 0; m_half = 0; m_ti = 0; m_hw = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         model_comb(take, er, code, idx);
         wr   = we && !stallM && !take;
         oc   = m_count;
         ocmp = m_compare;
         m_hw = hw_int;
         if (wr && waddr == 5'd9) begin
            m_count = wdata; m_half = 0;
         end else begin
            if (m_half) m_count = m_count + 1;
            m_half = !m_half;
         end
`ifdef CP0_TIMER_INT_EN
         if (wr && waddr == 5'd11) m_ti = 0;
         else if (oc == ocmp)      m_ti = 1;
`endif
         if (take && er) begin
            m_status[1] = 1'b0;
         end else if (take) begin
            if (!m_status[1]) begin
               m_epc = in_dsM ? pcM - 4 : pcM;
               m_cause[31] = in_dsM;
            end
            m_status[1]  = 1'b1;
            m_cause[6:2] = code;
            if (idx == 1)                 m_badv = pcM;
            else if (idx == 6 || idx == 7) m_badv = bad_addrM;
         end else if (wr) begin
            case (waddr)
               5'd11: m_compare = wdata;
               5'd12: m_status = 32'h0040_0000 | (wdata & 32'h0000_FF03);
               5'd13: m_cause[9:8] = wdata[9:8];
               5'd14: m_epc = wdata;
               default: ;
            endcase
         end
      end
   end

   // Single compare process: all outputs against the model, mid-cycle
   always @(negedge clk) begin
      bit take, er;
      logic [4:0] code;
      int idx;
      logic [31:0] et;
      if (m_valid) begin
         model_comb(take, er, code, idx);
         et = !take ? 32'd0 : er ? 32'hE : (idx == 0) ? 32'd1 : {27'd0, code};
         chk("m_excepttype", excepttype, et);
         chk("m_flush", 32'(flush), 32'(take));
         chk("m_newpc", newpc, !take ? 32'd0 : (er ? m_epc : VEC));
         chk("m_rdata", rdata, model_rdata(raddr));
         chk("m_epc", epc_o, m_epc);
         chk("m_status", status_o, m_status);
         chk("m_cause", cause_o, m_cause_read());
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stallM = 0; in_dsM = 0; syscallM = 0; breakM = 0; eretM = 0; riM = 0;
      ovM = 0; adel_ifM = 0; adel_memM = 0; adesM = 0; we = 0;
      waddr = 0; wdata = 0; hw_int = 0; bad_addrM = 0; pcM = 32'h1000;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      step(); idle();
      we = 1; waddr = a; wdata = d;
      $display("txn mtc0 reg%0d <= %h", a, d);
   endtask

   initial begin
      bit seen;
      logic [4:0] regs [7];
      regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
      rst = 1; raddr = 0; idle();
      syscallM = 1;
      step(); #1;
      $display("txn reset with syscall asserted");
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_excepttype", excepttype, 32'd0);
      chk("rst_newpc", newpc, 32'd0);

      step(); rst = 0; idle(); raddr = 12; #1;
      $display("txn mfc0 Status after reset");
      chk("status_reset", rdata, 32'h0040_0000);
      repeat (10) step();
      raddr = 9; #1;
      $display("txn mfc0 Count after 10 cycles");
      chk("count_10", rdata, 32'd5);

      step(); idle(); syscallM = 1; pcM = 32'hBFC0_1000; #1;
      $display("txn syscall pc=%h", pcM);
      chk("sys_flush", 32'(flush), 32'd1);
      chk("sys_newpc", newpc, VEC);
      chk("sys_type", excepttype, 32'h8);
      step(); idle(); #1;
      chk("sys_epc", epc_o, 32'hBFC0_1000);
      chk("sys_exl", 32'(status_o[1]), 32'd1);
      chk("sys_code", 32'(cause_o[6:2]), 32'h08);

      step(); idle(); stallM = 1; syscallM = 1; pcM = 32'h300; we = 1; waddr = 12; #1;
      $display("txn stalled syscall + mtc0 Status");
      chk("stall_flush", 32'(flush), 32'd0);
      chk("stall_type", excepttype, 32'd0);
      step(); idle(); #1;
      chk("stall_status", status_o, 32'h0040_0002);
      chk("stall_epc", epc_o, 32'hBFC0_1000);

      mtc0(12, 0);
      step(); idle(); ovM = 1; syscallM = 1; in_dsM = 1; pcM = 32'h100; #1;
      $display("txn ov+syscall in delay slot pc=%h", pcM);
      chk("ov_type", excepttype, 32'hC);
      step(); idle(); #1;
      chk("ov_code", 32'(cause_o[6:2]), 32'h0C);
      chk("ov_epc", epc_o, 32'hFC);
      chk("ov_bd", 32'(cause_o[31]), 32'd1);

      mtc0(12, 0);
      step(); idle(); adesM = 1; bad_addrM = 32'h8000_0003; pcM = 32'h200; #1;
      $display("txn ades addr=%h", bad_addrM);
      chk("ades_type", excepttype, 32'h5);
      step(); idle(); raddr = 8; #1;
      chk("ades_badv", rdata, 32'h8000_0003);
      chk("ades_code", 32'(cause_o[6:2]), 32'h05);
      chk("ades_epc", epc_o, 32'h200);

      step(); idle(); eretM = 1; we = 1; waddr = 14; wdata = 32'h55; #1;
      $display("txn eret + mtc0 EPC");
      chk("eret_newpc", newpc, 32'h200);
      chk("eret_type", excepttype, 32'hE);
      step(); idle(); #1;
      chk("eret_epc", epc_o, 32'h200);
      chk("eret_exl", 32'(status_o[1]), 32'd0);

      mtc0(9, 32'hFFFF_FFFF);
      step(); idle(); raddr = 9; #1;
      chk("count_max", rdata, 32'hFFFF_FFFF);
      step(); step(); #1;
      $display("txn Count wrap");
      chk("count_wrap", rdata, 32'd0);

      mtc0(9, 0);
      mtc0(11, 4);
      mtc0(12, 32'h0000_8001);
      step(); idle();
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #1;
         if (flush) begin
            seen = 1;
            chk("tmr_type", excepttype, 32'h1);
            chk("tmr_newpc", newpc, VEC);
         end else begin
            step();
         end
      end
      $display("txn timer interrupt wait");
`ifdef CP0_TIMER_INT_EN
      chk("tmr_taken", 32'(seen), 32'd1);
      step(); idle(); #1;
      chk("tmr_code", 32'(cause_o[6:2]), 32'h00);
      chk("tmr_exl", 32'(status_o[1]), 32'd1);
      chk("tmr_ti_set", 32'(cause_o[30]), 32'd1);
      mtc0(11, 1000);
      step(); idle(); #1;
      chk("tmr_ti_clr", 32'(cause_o[30]), 32'd0);
`else
      chk("tmr_taken", 32'(seen), 32'd0);
      chk("tmr_ti", 32'(cause_o[30]), 32'd0);
`endif
      mtc0(12, 0);

      $display("txn random phase start");
      repeat (3000) begin
         step();
         rst       = ($urandom_range(0, 499) == 0);
         stallM    = ($urandom_range(0, 7) == 0);
         in_dsM    = $urandom_range(0, 1) == 1;
         syscallM  = ($urandom_range(0, 15) == 0);
         breakM    = ($urandom_range(0, 15) == 0);
         eretM     = ($urandom_range(0, 9) == 0);
         riM       = ($urandom_range(0, 15) == 0);
         ovM       = ($urandom_range(0, 15) == 0);
         adel_ifM  = ($urandom_range(0, 19) == 0);
         adel_memM = ($urandom_range(0, 15) == 0);
         adesM     = ($urandom_range(0, 15) == 0);
         pcM       = {$urandom()} & 32'hFFFF_FFFC;
         bad_addrM = $urandom();
         hw_int    = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : 6'd0;
         we        = ($urandom_range(0, 2) == 0);
         waddr     = regs[$urandom_range(0, 6)];
         wdata     = $urandom();
         raddr     = regs[$urandom_range(0, 6)];
      end
      step(); idle(); rst = 0;
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cp0_exc.md
# cp0_exc

Coprocessor-0 register file and exception controller for the 5-stage MIPS core. It is the downstream end of the instruction decoder's privileged interface. It consumes the decoded `syscall`, `breakM`, `eret`, `invalidity` and `cp0write` flags in the M stage, together with overflow and address-error flags. From these it prioritises one exception per cycle, commits CP0 state, and drives the flush and redirect PC into the pipeline control.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: general exception entry address.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `stallM`  in  1  M stage stalled; blocks all commits except Count.
- `pcM`  in  32  PC of the M-stage instruction.
- `in_dsM`  in  1  M-stage instruction sits in a branch delay slot.
- `syscallM`, `breakM`, `eretM`, `riM`  in  1 each  decoded flags from maindec, valid in M.
- `ovM`  in  1  arithmetic overflow.
- `adel_ifM`  in  1  misaligned fetch.
- `adel_memM`  in  1  misaligned load.
- `adesM`  in  1  misaligned store.
- `bad_addrM`  in  32  faulting address.
- `hw_int`  in  6  external interrupt lines.
- `we`  in  1  mtc0 write.
- `waddr`  in  5  mtc0 target register.
- `wdata`  in  32  mtc0 data.
- `raddr`  in  5  mfc0 source register.
- `rdata`  out  32  mfc0 read data, combinational.
- `excepttype`  out  32  nonzero when an exception or eret is taken this cycle.
- `flush`  out  1  flush F..M stages.
- `newpc`  out  32  redirect target.
- `epc_o`, `status_o`, `cause_o`  out  32 each  register mirrors.

## Operation
- Implemented registers: BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13), EPC (14). Any other address reads 0 and ignores writes.
- Status writable fields: IM[15:8], EXL[1], IE[0]. BEV[22] is read-only 1.
- Cause writable field: IP[1:0]. IP[7:2] is sampled from `hw_int` every cycle. BD[31], TI[30] and ExcCode[6:2] are set by hardware only.
- An interrupt is pending when IE=1, EXL=0 and (IP & IM)≠0.
- Exception priority (highest first), with ExcCode:
  - Int 0x00
  - AdEL-fetch 0x04
  - RI 0x0A
  - Ov 0x0C
  - Sys 0x08
  - Bp 0x09
  - AdEL-data 0x04
  - AdES 0x05
  - eret (excepttype 32'h0E, no ExcCode)
- Exception entry:
  - If EXL=0: EPC ← `in_dsM` ? `pcM`−4 : `pcM`, and BD ← `in_dsM`.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL ← 1, ExcCode ← code.
  - Address errors: BadVAddr ← `bad_addrM`. For AdEL-fetch this is `pcM`.
  - `newpc` = `EXC_VECTOR`.
- eret: EXL ← 0, `newpc` = EPC, `flush` = 1.
- Same-cycle exception/eret and `we`: the exception or eret wins and the mtc0 write is dropped.
- A write to Compare clears TI.
- When `stallM`=1: `flush` and `excepttype` are forced to 0 and no commit occurs, but Count still advances.
- `rdata` returns the pre-write register value, with no same-cycle bypass.

## Timing
- `excepttype`, `flush` and `newpc` are combinational from the M-stage inputs in the same cycle. Register updates land on the next rising `clk`.
- Count increments by 1 every second cycle, driven by an internal toggle bit, and wraps 32'hFFFF_FFFF→0.
- TI sets on the cycle after Count becomes equal to Compare.
- An mtc0 write to Count takes effect next cycle and resets the toggle bit to 0.
- Reset values:
  - Status = 32'h0040_0000.
  - Cause, EPC, BadVAddr, Count, Compare and the toggle bit = 0.
  - During `rst`: `flush`=0, `excepttype`=0, `newpc`=0.
- Reset asserted mid-exception discards the pending commit.

## Configuration
- `CP0_TIMER_INT_EN` defined: Cause.IP7 = `hw_int[5]` | TI, so a Count==Compare match raises interrupt 7.
- `CP0_TIMER_INT_EN` undefined:
  - TI stays 0 and IP7 = `hw_int[5]`.
  - Count and Compare remain readable and writable; Count still increments.

## Structure
- Add to `defines.vh`:
  - CP0 register addresses.
  - ExcCode constants.
  - excepttype encodings.
  - Status/Cause bit positions.
- One sub-module, `exc_prio`: a pure combinational priority encoder. It takes the flag vector, pending-interrupt bit and eret, and returns {take, code, is_eret}.

## Test plan
- Reset, then mfc0 Status → 32'h0040_0000; Count reads 5 after 10 cycles.
- `syscallM`=1, `pcM`=32'hBFC0_1000, `in_dsM`=0:
  - `flush`=1, `newpc`=32'hBFC0_0380.
  - Next cycle: EPC=32'hBFC0_1000, EXL=1, ExcCode=0x08.
- `ovM` and `syscallM` together, `in_dsM`=1, `pcM`=32'h100:
  - ExcCode=0x0C, EPC=32'hFC, BD=1.
- `adesM`, `bad_addrM`=32'h8000_0003 → BadVAddr=32'h8000_0003, ExcCode=0x05.
- Timer interrupt:
  - Stimulus: mtc0 Status=32'h0000_8001, Compare=4.
  - With `CP0_TIMER_INT_EN`: interrupt taken, ExcCode=0x00, and the Compare rewrite clears TI.
  - Without the macro: no interrupt.
- Same-cycle eret and mtc0 EPC=32'h55:
  - `newpc` = old EPC, EPC unchanged, EXL=0.
